instruction_fetch_unit: RTL

//  Reader side of the 28-bit instruction ROM. Owns the program counter and drives the ROM's

---
 rtl/instruction_fetch_unit_pkg.sv | 37 +++
 rtl/instruction_field_decoder.sv | 19 +
 rtl/instruction_fetch_unit.sv | 77 +++++++
 3 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch path: opcodes, register indices and the
// fixed 28-bit instruction field layout.
package instruction_fetch_unit_pkg;

    typedef enum logic [3:0] {
        OpNop  = 4'h0,
        OpSto  = 4'h1,
        OpImul = 4'h6,
        OpLed  = 4'hC
    } opcode_e;

    localparam logic [7:0] R0 = 8'd0;
    localparam logic [7:0] R1 = 8'd1;
    localparam logic [7:0] R2 = 8'd2;
    localparam logic [7:0] R3 = 8'd3;
    localparam logic [7:0] R4 = 8'd4;
    localparam logic [7:0] R5 = 8'd5;
    localparam logic [7:0] R6 = 8'd6;
    localparam logic [7:0] R7 = 8'd7;

    localparam int unsigned InstrW    = 28;
    localparam int unsigned OpcodeMsb = 27;
    localparam int unsigned OpcodeLsb = 24;
    localparam int unsigned DestMsb   = 23;
    localparam int unsigned DestLsb   = 16;
    localparam int unsigned Src1Msb   = 15;
    localparam int unsigned Src1Lsb   = 8;
    localparam int unsigned Src0Msb   = 7;
    localparam int unsigned Src0Lsb   = 0;

    // Low 16 bits are either {src1, src0} or an STO literal.
    function automatic logic [InstrW-1:0] pack_instr(input opcode_e op, input logic [7:0] dest,
                                                     input logic [15:0] low);
        return {op, dest, low};
    endfunction

endpackage

// File: rtl/instruction_field_decoder.sv
// Pure combinational split of a 28-bit instruction word into its opcode/operand fields.
module instruction_field_decoder
    import instruction_fetch_unit_pkg::*;
(
    input  logic [InstrW-1:0] instr,
    output logic [3:0]        opcode,
    output logic [7:0]        dest,
    output logic [7:0]        src1,
    output logic [7:0]        src0,
    output logic [15:0]       immediate
);

    assign opcode    = instr[OpcodeMsb:OpcodeLsb];
    assign dest      = instr[DestMsb:DestLsb];
    assign src1      = instr[Src1Msb:Src1Lsb];
    assign src0      = instr[Src0Msb:Src0Lsb];
    assign immediate = instr[Src1Msb:Src0Lsb];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives the ROM address, holds one fetched instruction and hands
// it to execute over valid/ready. Branch redirects from execute flush the buffer.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH  = 16,
    parameter int unsigned            INSTR_WIDTH = 28,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = '0
) (
    input  logic                   Clock,
    input  logic                   Reset,
    output logic [ADDR_WIDTH-1:0]  oAddress,
    input  logic [INSTR_WIDTH-1:0] iInstruction,
    input  logic                   iBranchTaken,
    input  logic [ADDR_WIDTH-1:0]  iBranchTarget,
    input  logic                   iReady,
    output logic                   oValid,
    output logic [ADDR_WIDTH-1:0]  oPC,
    output logic [3:0]             oOpcode,
    output logic [7:0]             oDest,
    output logic [7:0]             oSrc1,
    output logic [7:0]             oSrc0,
    output logic [15:0]            oImmediate
);

    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]  ipc_q, ipc_d;
    logic [INSTR_WIDTH-1:0] buf_q, buf_d;
    logic                   valid_q, valid_d;
    logic                   load;

    always_comb begin
        pc_d    = pc_q;
        ipc_d   = ipc_q;
        buf_d   = buf_q;
        valid_d = valid_q;
        load    = !valid_q || iReady;
        // A redirect discards the buffered instruction even if execute is accepting it.
        if (iBranchTaken) begin
            pc_d    = iBranchTarget;
            valid_d = 1'b0;
        end else if (load) begin
            buf_d   = iInstruction;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            pc_q    <= RESET_PC;
            ipc_q   <= '0;
            buf_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            ipc_q   <= ipc_d;
            buf_q   <= buf_d;
            valid_q <= valid_d;
        end
    end

    assign oAddress = pc_q;
    assign oValid   = valid_q;
    assign oPC      = ipc_q;

    instruction_field_decoder u_decoder (
        .instr     (buf_q),
        .opcode    (oOpcode),
        .dest      (oDest),
        .src1      (oSrc1),
        .src0      (oSrc0),
        .immediate (oImmediate)
    );

endmodule
